// File: rtl/icap_loader_pkg.sv
// ---------------------------------------------------------------------------
// icap_loader_pkg
// Shared definitions for the ICAP loader slice:
//   - ICAP data width and the ICAP sync word constant
//   - loader state encodings, plus the enum type built on them
// ---------------------------------------------------------------------------
package icap_loader_pkg;

    localparam int          ICAP_DWIDTH    = 32;
    localparam logic [31:0] ICAP_SYNC_WORD = 32'hAA995566;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ARM   = ST_ARM,
        S_WRITE = ST_WRITE,
        S_GAP   = ST_GAP,
        S_DONE  = ST_DONE
    } icap_state_e;

endpackage

// File: rtl/icap_loader_bitswap.sv
// ---------------------------------------------------------------------------
// icap_bitswap
// Purely combinational per-byte bit reversal used for ICAP data ordering.
// Ports:
//   data_i  in  DWIDTH  word as received from the stream
//   data_o  out DWIDTH  word in ICAP order (reversed per byte when SWAP_BITS=1)
// ---------------------------------------------------------------------------
module icap_bitswap
    import icap_loader_pkg::*;
#(
    parameter int DWIDTH    = ICAP_DWIDTH,
    parameter int SWAP_BITS = 1
) (
    input  logic [DWIDTH-1:0] data_i,
    output logic [DWIDTH-1:0] data_o
);

    genvar k, j;
    generate
        if (SWAP_BITS != 0) begin : g_swap
            for (k = 0; k < DWIDTH / 8; k++) begin : g_byte
                for (j = 0; j < 8; j++) begin : g_bit
                    assign data_o[8*k + j] = data_i[8*k + 7 - j];
                end
            end
        end else begin : g_pass
            assign data_o = data_i;
        end
    endgenerate

endmodule

// File: rtl/icap_loader.sv
// ---------------------------------------------------------------------------
// icap_loader
// Final stage of the partial-reconfiguration path: takes the 32-bit config
// word stream and drives the ICAP write port, one bitstream per tlast.
// Ports:
//   rclk, rresetn          ICAP clock, asynchronous active-low reset
//   enable                 level; 0 pauses word acceptance
//   abort                  pulse; terminates the current bitstream
//   err_clr                pulse; clears the sticky error flags
//   s_axis_*               config word stream (tvalid/tready/tdata/tkeep/tlast)
//   icap_csib/rdwrb/i      ICAP write port (select low, direction, data)
//   busy, done             bitstream in progress / end-of-bitstream pulse
//   err_keep, err_abort    sticky: partial word dropped / bitstream aborted
//   word_cnt               words written in the current or last bitstream
// All outputs are registered.
// ---------------------------------------------------------------------------
module icap_loader
    import icap_loader_pkg::*;
#(
    parameter int DWIDTH     = ICAP_DWIDTH,
    parameter int SWAP_BITS  = 1,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  rclk,
    input  logic                  rresetn,
    input  logic                  enable,
    input  logic                  abort,
    input  logic                  err_clr,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DWIDTH-1:0]     s_axis_tdata,
    input  logic [DWIDTH/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  icap_csib,
    output logic                  icap_rdwrb,
    output logic [DWIDTH-1:0]     icap_i,
    output logic                  busy,
    output logic                  done,
    output logic                  err_keep,
    output logic                  err_abort,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    icap_state_e            state_q;
    logic                   tready_q;
    logic                   csib_q;
    logic                   rdwrb_q;
    logic [DWIDTH-1:0]      icap_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_keep_q;
    logic                   err_abort_q;
    logic [CNT_WIDTH-1:0]   word_cnt_q;
    logic [CNT_WIDTH-1:0]   word_cnt_d;
    logic [3:0]             gap_q;
    logic [DWIDTH-1:0]      swap_d;
    logic                   handshake;

    icap_bitswap #(
        .DWIDTH    (DWIDTH),
        .SWAP_BITS (SWAP_BITS)
    ) u_bitswap (
        .data_i (s_axis_tdata),
        .data_o (swap_d)
    );

    assign handshake  = s_axis_tvalid & tready_q;
    // Saturating increment: the counter sticks at all ones.
    assign word_cnt_d = (word_cnt_q == {CNT_WIDTH{1'b1}}) ? word_cnt_q
                                                          : word_cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge rclk or negedge rresetn) begin
        if (!rresetn) begin
            state_q     <= S_IDLE;
            tready_q    <= 1'b0;
            csib_q      <= 1'b1;
            rdwrb_q     <= 1'b1;
            icap_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_keep_q  <= 1'b0;
            err_abort_q <= 1'b0;
            word_cnt_q  <= '0;
            gap_q       <= '0;
        end else begin
            // CSIB is only pulled low in the cycle right after an accepted
            // full word; every other cycle deselects the ICAP.
            csib_q <= 1'b1;
            done_q <= 1'b0;
            // Clear first so that any error set later in this block wins.
            if (err_clr) begin
                err_keep_q  <= 1'b0;
                err_abort_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    tready_q <= 1'b0;
                    if (s_axis_tvalid && enable) begin
                        // Direction flips to write while CSIB is still high.
                        state_q    <= S_ARM;
                        rdwrb_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        word_cnt_q <= '0;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        err_abort_q <= 1'b1;
                        gap_q       <= GAP_LOAD;
                        state_q     <= S_GAP;
                    end else begin
                        tready_q <= enable;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        // A word handshaken in the abort cycle is discarded.
                        tready_q    <= 1'b0;
                        err_abort_q <= 1'b1;
                        gap_q       <= GAP_LOAD;
                        state_q     <= S_GAP;
                    end else begin
                        tready_q <= enable;
                        if (handshake) begin
                            if (&s_axis_tkeep) begin
                                csib_q     <= 1'b0;
                                icap_q     <= swap_d;
                                word_cnt_q <= word_cnt_d;
                            end else begin
                                err_keep_q <= 1'b1;
                            end
                            if (s_axis_tlast) begin
                                tready_q <= 1'b0;
                                gap_q    <= GAP_LOAD;
                                state_q  <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // The first GAP cycle carries the final write, so the
                    // counter runs one extra step to leave GAP_CYCLES idle
                    // cycles with CSIB high.
                    if (gap_q == 4'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        rdwrb_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign icap_csib     = csib_q;
    assign icap_rdwrb    = rdwrb_q;
    assign icap_i        = icap_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_keep      = err_keep_q;
    assign err_abort     = err_abort_q;
    assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_icap_loader.sv
// ---------------------------------------------------------------------------
// tb_icap_loader
// Self-checking bench for icap_loader. Expected ICAP words and the cycle in
// which each must appear are queued when the word is handed to the DUT, and
// a background monitor pops and compares them whenever CSIB is low.
// ---------------------------------------------------------------------------
module tb_icap_loader;
    import icap_loader_pkg::*;

    localparam int GAP = 4;
    localparam int CW  = 24;

    logic          rclk = 1'b0;
    logic          rresetn;
    logic          enable;
    logic          abort;
    logic          err_clr;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [31:0]   s_axis_tdata;
    logic [3:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic          icap_csib;
    logic          icap_rdwrb;
    logic [31:0]   icap_i;
    logic          busy;
    logic          done;
    logic          err_keep;
    logic          err_abort;
    logic [CW-1:0] word_cnt;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          writeCycs[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          lastWriteCyc;
    int          doneCyc;
    logic [CW-1:0] doneWordCnt;
    bit          doneSeen;
    logic        prevCsib;
    logic        prevRdwrb;

    icap_loader #(
        .DWIDTH     (32),
        .SWAP_BITS  (1),
        .GAP_CYCLES (GAP),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk          (rclk),
        .rresetn       (rresetn),
        .enable        (enable),
        .abort         (abort),
        .err_clr       (err_clr),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .icap_csib     (icap_csib),
        .icap_rdwrb    (icap_rdwrb),
        .icap_i        (icap_i),
        .busy          (busy),
        .done          (done),
        .err_keep      (err_keep),
        .err_abort     (err_abort),
        .word_cnt      (word_cnt)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) cyc <= cyc + 1;

    function automatic logic [31:0] swapModel(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
                r[8*k + j] = d[8*k + 7 - j];
        return r;
    endfunction

    // Background checker: ICAP writes against the scoreboard, RDWRB stability
    // around any selected cycle, and capture of the done pulse.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge rclk);
            if (rresetn === 1'b1) begin
                if (icap_csib === 1'b0 || prevCsib === 1'b0) begin
                    total++;
                    if (icap_rdwrb !== prevRdwrb || icap_rdwrb !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL rdwrb_stable: rdwrb=%b prev=%b csib=%b cyc=%0d",
                                 icap_rdwrb, prevRdwrb, icap_csib, cyc);
                    end
                end
                if (icap_csib === 1'b0) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_write: icap_i=%h cyc=%0d", icap_i, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (icap_i !== e.data || cyc != e.cyc) begin
                            bad++;
                            $display("[TB] FAIL icap_write: got %h at cyc %0d, expected %h at cyc %0d",
                                     icap_i, cyc, e.data, e.cyc);
                        end
                    end
                    lastWriteCyc = cyc;
                    writeCycs.push_back(cyc);
                end
                if (done === 1'b1) begin
                    doneSeen    = 1'b1;
                    doneCyc     = cyc;
                    doneWordCnt = word_cnt;
                end
            end
            prevCsib  = icap_csib;
            prevRdwrb = icap_rdwrb;
        end
    endtask

    // Presents one word and returns right after the edge that accepts it.
    task automatic sendWord(input logic [31:0] d, input logic [3:0] k,
                            input logic l, input logic [31:0] expd);
        int waited;
        @(negedge rclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        waited = 0;
        while (s_axis_tready !== 1'b1) begin
            @(negedge rclk);
            waited++;
            if (waited > 200) begin
                total++;
                bad++;
                $display("[TB] FAIL accept_timeout: tready=%b after %0d cycles, expected 1",
                         s_axis_tready, waited);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        if (k == 4'hF) sb.push_back('{expd, cyc + 1});
        @(posedge rclk);
    endtask

    task automatic endStream();
        @(negedge rclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!doneSeen && n < 100) begin
            @(negedge rclk);
            n++;
        end
        total++;
        if (!doneSeen) begin
            bad++;
            $display("[TB] FAIL %s_done_timeout: done=0 after %0d cycles, expected pulse", name, n);
        end
    endtask

    task automatic checkEmpty(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_pending: %0d words not written, expected 0", name, sb.size());
        end
    endtask

    task automatic startTest();
        doneSeen = 1'b0;
        writeCycs.delete();
    endtask

    task automatic test_reset();
        rresetn = 1'b0;
        enable = 1'b1; abort = 1'b0; err_clr = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
        repeat (3) @(negedge rclk);
        total++;
        if ({icap_csib, icap_rdwrb, s_axis_tready, busy, done, err_keep, err_abort} !== 7'b1100000
            || icap_i !== 32'h0 || word_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL reset_values: csib=%b rdwrb=%b tready=%b busy=%b done=%b ek=%b ea=%b i=%h cnt=%0d",
                     icap_csib, icap_rdwrb, s_axis_tready, busy, done, err_keep, err_abort, icap_i, word_cnt);
        end
        rresetn = 1'b1;
        repeat (2) @(negedge rclk);
        total++;
        if (icap_csib !== 1'b1 || s_axis_tready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: csib=%b tready=%b busy=%b, expected 1/0/0",
                     icap_csib, s_axis_tready, busy);
        end
    endtask

    task automatic test_basic();
        startTest();
        sendWord(32'hFFFFFFFF, 4'hF, 1'b0, 32'hFFFFFFFF);
        sendWord(ICAP_SYNC_WORD, 4'hF, 1'b0, 32'h5599AA66);
        sendWord(32'h20000000, 4'hF, 1'b1, 32'h04000000);
        endStream();
        waitDone("basic");
        checkEmpty("basic");
        total++;
        if (writeCycs.size() != 3 || writeCycs[2] - writeCycs[0] != 2) begin
            bad++;
            $display("[TB] FAIL basic_contiguous: %0d writes, span %0d, expected 3 writes span 2",
                     writeCycs.size(), (writeCycs.size() == 3) ? writeCycs[2] - writeCycs[0] : -1);
        end
        total++;
        if (doneCyc - lastWriteCyc != GAP + 1) begin
            bad++;
            $display("[TB] FAIL basic_gap: done %0d cycles after last write, expected %0d",
                     doneCyc - lastWriteCyc, GAP + 1);
        end
        total++;
        if (doneWordCnt !== 24'd3) begin
            bad++;
            $display("[TB] FAIL basic_word_cnt: %0d, expected 3", doneWordCnt);
        end
        repeat (3) @(negedge rclk);
        total++;
        if (word_cnt !== 24'd3 || busy !== 1'b0 || icap_rdwrb !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_hold: cnt=%0d busy=%b rdwrb=%b, expected 3/0/1",
                     word_cnt, busy, icap_rdwrb);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [6];
        startTest();
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        sendWord(w[0], 4'hF, 1'b0, swapModel(w[0]));
        sendWord(w[1], 4'hF, 1'b0, swapModel(w[1]));
        fork
            begin
                for (int i = 2; i < 6; i++) sendWord(w[i], 4'hF, i == 5, swapModel(w[i]));
                endStream();
            end
            begin
                @(negedge rclk);
                enable = 1'b0;
                repeat (5) @(negedge rclk);
                enable = 1'b1;
            end
        join
        waitDone("bp");
        checkEmpty("bp");
        total++;
        if (writeCycs.size() != 6 || writeCycs[3] - writeCycs[2] != 6) begin
            bad++;
            $display("[TB] FAIL bp_pause: %0d writes, gap %0d, expected 6 writes gap 6",
                     writeCycs.size(), (writeCycs.size() == 6) ? writeCycs[3] - writeCycs[2] : -1);
        end
        total++;
        if (doneWordCnt !== 24'd6) begin
            bad++;
            $display("[TB] FAIL bp_word_cnt: %0d, expected 6", doneWordCnt);
        end
        repeat (2) @(negedge rclk);
    endtask

    task automatic test_partial_keep();
        logic [31:0] d;
        startTest();
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            sendWord(d, (i == 1) ? 4'b0111 : 4'hF, i == 3, swapModel(d));
        end
        endStream();
        waitDone("keep");
        checkEmpty("keep");
        total++;
        if (doneWordCnt !== 24'd3 || err_keep !== 1'b1) begin
            bad++;
            $display("[TB] FAIL keep_status: cnt=%0d err_keep=%b, expected 3/1", doneWordCnt, err_keep);
        end
        @(negedge rclk);
        err_clr = 1'b1;
        @(negedge rclk);
        err_clr = 1'b0;
        total++;
        if (err_keep !== 1'b0) begin
            bad++;
            $display("[TB] FAIL keep_clear: err_keep=%b, expected 0", err_keep);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        startTest();
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            sendWord(d, 4'hF, 1'b0, swapModel(d));
        end
        @(negedge rclk);
        s_axis_tvalid = 1'b0;
        abort = 1'b1;
        @(negedge rclk);
        abort = 1'b0;
        total++;
        if (icap_csib !== 1'b1 || err_abort !== 1'b1 || s_axis_tready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_react: csib=%b err_abort=%b tready=%b, expected 1/1/0",
                     icap_csib, err_abort, s_axis_tready);
        end
        waitDone("abort");
        checkEmpty("abort");
        total++;
        if (doneWordCnt !== 24'd10) begin
            bad++;
            $display("[TB] FAIL abort_word_cnt: %0d, expected 10", doneWordCnt);
        end
        repeat (2) @(negedge rclk);
        total++;
        if (busy !== 1'b0 || s_axis_tready !== 1'b0 || err_abort !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_idle: busy=%b tready=%b err_abort=%b, expected 0/0/1",
                     busy, s_axis_tready, err_abort);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        startTest();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            sendWord(d, 4'hF, 1'b0, swapModel(d));
        end
        #2;
        rresetn = 1'b0;
        #1;
        total++;
        if (icap_csib !== 1'b1 || icap_rdwrb !== 1'b1 || busy !== 1'b0 || err_abort !== 1'b0
            || err_keep !== 1'b0 || word_cnt !== '0 || s_axis_tready !== 1'b0 || icap_i !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_reset: csib=%b rdwrb=%b busy=%b ea=%b ek=%b cnt=%0d tready=%b i=%h",
                     icap_csib, icap_rdwrb, busy, err_abort, err_keep, word_cnt, s_axis_tready, icap_i);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sb.delete();
        @(negedge rclk);
        rresetn = 1'b1;
        repeat (2) @(negedge rclk);
        startTest();
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            sendWord(d, 4'hF, i == 2, swapModel(d));
        end
        endStream();
        waitDone("post_reset");
        checkEmpty("post_reset");
        total++;
        if (doneWordCnt !== 24'd3) begin
            bad++;
            $display("[TB] FAIL post_reset_word_cnt: %0d, expected 3", doneWordCnt);
        end
    endtask

    initial begin
        prevCsib  = 1'b1;
        prevRdwrb = 1'b1;
        lastWriteCyc = 0;
        doneCyc = 0;
        doneWordCnt = '0;
        doneSeen = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_partial_keep();
        test_abort();
        test_reset_mid_write();
        repeat (3) @(negedge rclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icap_loader.md
Name: icap_loader

Overview:
- Final stage of the partial-reconfiguration path.
- Consumes the 32-bit configuration word stream produced by the config buffer in the rclk domain and drives the FPGA ICAP write port (CSIB/RDWRB/I).
- Applies ICAP per-byte bit ordering, enforces the RDWRB-stable-while-selected rule, frames one bitstream per tlast, and reports status (busy/done/errors/word count) to the control block.

Parameters:
- DWIDTH, 32, stream and ICAP data width; only 32 is supported.
- SWAP_BITS, 1, 1 = bit-reverse within each byte before driving icap_i; 0 = pass-through.
- GAP_CYCLES, 4, cycles CSIB is held high after the last word before done; legal range 1..15.
- CNT_WIDTH, 24, width of the written-word counter.

Ports:
- rclk  in  1  ICAP clock.
- rresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; 0 pauses acceptance of words.
- abort  in  1  single-cycle pulse; terminates the current bitstream.
- err_clr  in  1  single-cycle pulse; clears sticky error flags.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  word accept.
- s_axis_tdata  in  DWIDTH  configuration word.
- s_axis_tkeep  in  DWIDTH/8  byte enables.
- s_axis_tlast  in  1  last word of bitstream.
- icap_csib  out  1  ICAP select, active low.
- icap_rdwrb  out  1  ICAP direction; 0 = write.
- icap_i  out  DWIDTH  ICAP write data.
- busy  out  1  bitstream in progress.
- done  out  1  one-cycle pulse at end of bitstream.
- err_keep  out  1  sticky: partial-tkeep word seen.
- err_abort  out  1  sticky: bitstream aborted.
- word_cnt  out  CNT_WIDTH  words written in current/last bitstream.

Behaviour:
- Clock and reset: clock is rclk; reset is rresetn, asynchronous, active-low.
- Reset values of all outputs: icap_csib=1, icap_rdwrb=1, icap_i=0, s_axis_tready=0, busy=0, done=0, err_keep=0, err_abort=0, word_cnt=0.
- All outputs are registered; no combinational path from input to output.
- State machine, IDLE -> ARM -> WRITE -> GAP -> DONE -> IDLE:
  - IDLE: tready=0, csib=1, rdwrb=1. On tvalid=1 and enable=1, go to ARM.
  - ARM: one cycle; rdwrb<=0 while csib=1; busy<=1; word_cnt<=0. Then go to WRITE.
  - WRITE: tready=enable. On a handshake with tkeep all ones, the next cycle drives csib=0 and icap_i=swap(tdata), and word_cnt increments (saturates at all ones). With no handshake, the next cycle has csib=1 and icap_i holds its value. Latency from accept to ICAP is exactly 1 cycle.
  - WRITE, partial word: on a handshake with tkeep != all ones, the word is dropped (csib stays 1, no count) and err_keep<=1. Its tlast is still honoured.
  - WRITE, last word: on a handshake with tlast=1, tready<=0 and the state goes to GAP.
  - GAP: csib=1, rdwrb=0 for GAP_CYCLES cycles (4-bit down-counter). Then go to DONE.
  - DONE: one cycle; done=1, rdwrb<=1, busy<=0. Then go to IDLE.
- Bit swap: icap_i[8k+j] = tdata[8k+7-j] for k=0..3, j=0..7.
- rdwrb changes only while csib=1 is driven.
- enable=0 in WRITE: tready drops in the next cycle; one word already accepted is still written. Resumption does not re-enter ARM.
- abort:
  - In ARM/WRITE: tready<=0, csib<=1 next cycle, err_abort<=1, go to GAP. The stream remainder is left unconsumed upstream.
  - In IDLE/GAP/DONE: ignored.
- err_clr and a simultaneous error set in the same cycle: set wins.
- word_cnt holds its final value after DONE until the next ARM.
- Reset mid-transfer: immediate return to reset values, including csib=1. No gap is guaranteed, because reset is asynchronous.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE/ST_ARM/ST_WRITE/ST_GAP/ST_DONE;
  - ICAP_DWIDTH=32;
  - the ICAP sync word constant 32'hAA995566, for bench checking.
- One sub-module: icap_bitswap, a purely combinational per-byte reversal with a SWAP_BITS parameter. Everything else lives in icap_loader.

Test Plan:
- Basic bitstream: 3 words FFFFFFFF, AA995566, 20000000 with tlast on the 3rd, SWAP_BITS=1.
  - icap_i = FFFFFFFF, 5599AA66, 04000000 with csib=0 for 3 cycles, each 1 cycle after its accept.
  - done pulses GAP_CYCLES+1 cycles after the last write; word_cnt=3.
- Backpressure: enable dropped for 5 cycles after word 2 of 6.
  - csib=1 for exactly those gap cycles; all 6 words written in order; word_cnt=6.
- Partial keep: word 2 of 4 sent with tkeep=4'b0111.
  - Word not driven; err_keep=1; word_cnt=3; done still pulses.
  - err_clr then clears err_keep.
- Abort: abort pulse after 10 of 20 words.
  - csib=1 next cycle, err_abort=1, word_cnt=10, done pulses, busy=0, tready stays 0 in IDLE.
- Reset mid-WRITE: rresetn low asynchronously during word 5.
  - csib=1, rdwrb=1 immediately; all status outputs 0.
  - A subsequent bitstream completes normally.
- RDWRB check: an assertion across all the above that rdwrb never changes in a cycle where csib is driven 0.
